// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache.
//   state_t     : controller states
//   TAG_W       : tag width for the default geometry
//   get_tag()   : upper address bits above the index field
//   get_index() : lower address bits selecting a line
// The helpers take a 32-bit zero-extended address and the index width so that
// any parametrisation of the top level (ADDR_W <= 32) can reuse them.
package cache_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INDEX_W_DEF = 10;
  localparam int TAG_W       = ADDR_W_DEF - INDEX_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE,
    DONE
  } state_t;

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int index_w);
    return addr >> index_w;
  endfunction

  function automatic logic [31:0] get_index(input logic [31:0] addr, input int index_w);
    return addr & ((32'd1 << index_w) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Single-port synchronous RAM, read-first, no reset on contents.
//   clk   : clock
//   we    : write enable for addr
//   addr  : line index (read and write share it)
//   wdata : write data
//   rdata : registered read data; on a write cycle it returns the old contents
module cache_data_ram #(
  parameter int INDEX_W = 10,
  parameter int W       = 64
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] addr,
  input  logic [W-1:0]       wdata,
  output logic [W-1:0]       rdata
);

  logic [W-1:0] mem_array [2**INDEX_W];
  logic [W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
    rdata_reg <= mem_array[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
//   CPU side : cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_flush in,
//              cpu_busy/cpu_done/cpu_rdata out
//   Mem side : mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in
//   Stats    : hit_count/miss_count, saturating
// Reset (gen_reset) is synchronous, active-high; it aborts any transaction and
// invalidates every line. Data and tag RAM contents are never reset.
module cache_dm_wt
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int LINE_W  = 64,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LINE_W-1:0] cpu_wdata,
  input  logic              cpu_flush,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [LINE_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TAG_BITS = ADDR_W - INDEX_W;
  localparam int LINES    = 2**INDEX_W;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]   addr_reg;
  logic                we_reg;
  logic [LINE_W-1:0]   wdata_reg;
  logic [LINES-1:0]    valid_reg;
  logic [LINE_W-1:0]   rdata_reg;
  logic                mem_req_reg;
  logic [CNT_W-1:0]    hit_reg;
  logic [CNT_W-1:0]    miss_reg;

  logic [INDEX_W-1:0]  req_index;
  logic [INDEX_W-1:0]  cap_index;
  logic [TAG_BITS-1:0] cap_tag;
  logic [INDEX_W-1:0]  ram_addr;
  logic [LINE_W-1:0]   data_rdata;
  logic [LINE_W-1:0]   data_wdata;
  logic [TAG_BITS-1:0] tag_rdata;
  logic                data_we;
  logic                tag_we;
  logic                accept;
  logic                ack_seen;
  logic                hit;
  logic                in_mem_state;

  assign req_index = INDEX_W'(get_index(32'(cpu_addr), INDEX_W));
  assign cap_index = INDEX_W'(get_index(32'(addr_reg), INDEX_W));
  assign cap_tag   = TAG_BITS'(get_tag(32'(addr_reg), INDEX_W));

  // Flush wins over a simultaneous request; the requester keeps cpu_req high.
  assign accept       = (state_reg == IDLE) && cpu_req && !cpu_flush;
  // An ack only counts once our own request is visible to memory.
  assign ack_seen     = mem_req_reg && mem_ack;
  assign hit          = valid_reg[cap_index] && (tag_rdata == cap_tag);
  assign in_mem_state = (state_reg == REFILL) || (state_reg == WRITE);

  // The RAMs are read at the incoming index while idle so the line is ready
  // in LOOKUP; afterwards they stay on the captured index.
  assign ram_addr   = (state_reg == IDLE) ? req_index : cap_index;
  assign data_we    = ((state_reg == LOOKUP) && we_reg && hit) ||
                      ((state_reg == REFILL) && ack_seen);
  assign data_wdata = (state_reg == REFILL) ? mem_rdata : wdata_reg;
  assign tag_we     = (state_reg == REFILL) && ack_seen;

  cache_data_ram #(.INDEX_W(INDEX_W), .W(LINE_W)) u_data_ram (
    .clk   (clk),
    .we    (data_we),
    .addr  (ram_addr),
    .wdata (data_wdata),
    .rdata (data_rdata)
  );

  cache_data_ram #(.INDEX_W(INDEX_W), .W(TAG_BITS)) u_tag_ram (
    .clk   (clk),
    .we    (tag_we),
    .addr  (ram_addr),
    .wdata (cap_tag),
    .rdata (tag_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (gen_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (we_reg)   state_next = WRITE;
        else if (hit) state_next = DONE;
        else          state_next = REFILL;
      end
      REFILL: begin
        if (ack_seen) state_next = DONE;
      end
      WRITE: begin
        if (ack_seen) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    cpu_busy  = (state_reg != IDLE);
    cpu_done  = (state_reg == DONE);
    mem_we    = (state_reg == WRITE);
    mem_addr  = in_mem_state ? addr_reg : '0;
    mem_wdata = (state_reg == WRITE) ? wdata_reg : '0;
  end

  assign cpu_rdata  = rdata_reg;
  assign mem_req    = mem_req_reg;
  assign hit_count  = hit_reg;
  assign miss_count = miss_reg;

  // Datapath and bookkeeping registers
  always_ff @(posedge clk) begin
    if (gen_reset) begin
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      valid_reg   <= '0;
      rdata_reg   <= '0;
      mem_req_reg <= 1'b0;
      hit_reg     <= '0;
      miss_reg    <= '0;
    end else begin
      if (accept) begin
        addr_reg  <= cpu_addr;
        we_reg    <= cpu_we;
        wdata_reg <= cpu_wdata;
      end

      if ((state_reg == IDLE) && cpu_flush) begin
        valid_reg <= '0;
      end else if (tag_we) begin
        valid_reg[cap_index] <= 1'b1;
      end

      // Request rises one cycle into REFILL/WRITE and drops right after the ack.
      mem_req_reg <= in_mem_state && !ack_seen;

      if (state_reg == LOOKUP) begin
        if (hit) begin
          if (hit_reg != '1) hit_reg <= hit_reg + 1'b1;
          if (!we_reg) rdata_reg <= data_rdata;
        end else begin
          if (miss_reg != '1) miss_reg <= miss_reg + 1'b1;
        end
      end

      if (tag_we) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_dm_wt.sv
// Self-checking bench for cache_dm_wt: directed scenarios followed by random
// traffic, compared against a reference of the cache's observable behaviour
// (line valid/tag table, backing memory contents, hit/miss tallies).
module tb_cache_dm_wt;

  localparam int ADDR_W  = 16;
  localparam int INDEX_W = 10;
  localparam int LINE_W  = 64;
  localparam int CNT_W   = 32;
  localparam int LINES   = 1024;

  logic              clk = 1'b0;
  logic              gen_reset = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [LINE_W-1:0] cpu_wdata = '0;
  logic              cpu_flush = 1'b0;
  logic              cpu_busy;
  logic              cpu_done;
  logic [LINE_W-1:0] cpu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  cache_dm_wt #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .gen_reset  (gen_reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_flush  (cpu_flush),
    .cpu_busy   (cpu_busy),
    .cpu_done   (cpu_done),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Backing memory image, written only by the main sequence.
  logic [LINE_W-1:0] mem_store [int];

  function automatic logic [LINE_W-1:0] mem_read(input int a);
    if (mem_store.exists(a)) return mem_store[a];
    return 64'hD000_0000_0000_0000 | 64'(a);
  endfunction

  // Memory model controls (written by main) and its operation record (written by the model).
  logic              mem_auto = 1'b1;
  int                stale_req = 0;
  int                op_cnt = 0;
  logic              op_we = 1'b0;
  logic [ADDR_W-1:0] op_addr = '0;
  logic [LINE_W-1:0] op_wdata = '0;
  int                op_cyc = 0;

  // Memory model: acknowledges 3 cycles after seeing mem_req, one-cycle ack.
  initial begin
    int wait_cnt;
    int stale_done;
    wait_cnt   = 0;
    stale_done = 0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (stale_done != stale_req) begin
        stale_done++;
        mem_ack   = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (mem_auto && mem_req) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          mem_ack   = 1'b1;
          op_we     = mem_we;
          op_addr   = mem_addr;
          op_wdata  = mem_wdata;
          op_cyc    = cyc;
          op_cnt    = op_cnt + 1;
          mem_rdata = mem_we ? '0 : mem_read(int'(mem_addr));
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Reference: which address each line currently holds, plus statistics.
  bit ref_valid [LINES];
  int ref_tag   [LINES];
  int ref_hits  = 0;
  int ref_misses = 0;

  task automatic ref_clear_lines();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // One complete CPU transaction with all its expectations.
  task automatic do_txn(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wd, input bit flush_first,
                        output logic [LINE_W-1:0] rd);
    int  idx;
    int  tag;
    bit  exp_hit;
    int  ops0;
    int  exp_ops;
    int  lat;
    int  done_cyc;
    bit  got;
    idx      = int'(addr) % LINES;
    tag      = int'(addr) / LINES;
    ops0     = op_cnt;
    got      = 1'b0;
    done_cyc = 0;
    rd       = '0;

    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_flush = flush_first;
    if (flush_first) begin
      @(negedge clk);
      chk("flush_blocks_request", {63'd0, cpu_busy}, 64'd0);
      cpu_flush = 1'b0;
      ref_clear_lines();
    end
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);

    lat = 1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      cpu_req = 1'b0;
      if (cpu_done) begin
        got      = 1'b1;
        done_cyc = cyc;
        rd       = cpu_rdata;
      end
    end
    chk("done_seen", {63'd0, got}, 64'd1);

    exp_ops = (we || !exp_hit) ? 1 : 0;
    chk("mem_op_count", 64'(op_cnt - ops0), 64'(exp_ops));
    if (exp_ops == 1) begin
      chk("mem_op_we", {63'd0, op_we}, {63'd0, we});
      chk("mem_op_addr", 64'(op_addr), 64'(addr));
      if (we) chk("mem_op_wdata", op_wdata, wd);
      chk("done_after_ack", 64'(done_cyc), 64'(op_cyc + 1));
    end else begin
      chk("hit_latency", 64'(lat), 64'd3);
    end
    if (!we) chk("read_data", rd, mem_read(int'(addr)));

    if (exp_hit) ref_hits++;
    else ref_misses++;
    if (!we && !exp_hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
    end
    if (we) mem_store[int'(addr)] = wd;

    chk("hit_count", 64'(hit_count), 64'(ref_hits));
    chk("miss_count", 64'(miss_count), 64'(ref_misses));

    @(negedge clk);
    chk("done_one_cycle", {63'd0, cpu_done}, 64'd0);
    chk("idle_after_done", {63'd0, cpu_busy}, 64'd0);
    $display("txn we=%0d addr=%h flush=%0d hit=%0d lat=%0d rdata=%h", we, addr,
             flush_first, exp_hit, lat, rd);
  endtask

  initial begin
    logic [LINE_W-1:0] rd;
    bit                saw;
    ref_clear_lines();
    for (int i = 0; i < LINES; i++) ref_tag[i] = 0;
    mem_store[16'h0005] = 64'hAAAA_0000_0000_0001;
    mem_store[16'h0405] = 64'hBBBB_0000_0000_0002;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, cpu_busy}, 64'd0);
    chk("reset_done", {63'd0, cpu_done}, 64'd0);
    chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset_mem_we", {63'd0, mem_we}, 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_rdata", cpu_rdata, 64'd0);
    chk("reset_hits", 64'(hit_count), 64'd0);
    chk("reset_misses", 64'(miss_count), 64'd0);
    gen_reset = 1'b0;

    // Directed scenarios
    do_txn(1'b0, 16'h0005, '0, 1'b0, rd);
    chk("first_refill_data", rd, 64'hAAAA_0000_0000_0001);
    chk("first_miss_count", 64'(miss_count), 64'd1);
    do_txn(1'b0, 16'h0005, '0, 1'b0, rd);
    chk("reread_hit_count", 64'(hit_count), 64'd1);
    do_txn(1'b0, 16'h0405, '0, 1'b0, rd);
    chk("alias_refill_data", rd, 64'hBBBB_0000_0000_0002);
    do_txn(1'b0, 16'h0005, '0, 1'b0, rd);
    chk("evicted_miss_count", 64'(miss_count), 64'd3);
    do_txn(1'b1, 16'h0405, 64'h1234, 1'b0, rd);
    do_txn(1'b1, 16'h0405, 64'h1234, 1'b0, rd);
    do_txn(1'b0, 16'h0405, '0, 1'b0, rd);
    chk("write_hit_updates_line", rd, 64'h1234);
    do_txn(1'b1, 16'h0010, 64'h5555, 1'b0, rd);
    do_txn(1'b0, 16'h0010, '0, 1'b0, rd);
    do_txn(1'b0, 16'h0405, '0, 1'b1, rd);

    // Reset in the middle of a refill, then a late ack
    mem_auto = 1'b0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0123;
    @(negedge clk);
    cpu_req = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20 && !saw; i++) begin
      @(negedge clk);
      if (mem_req) saw = 1'b1;
    end
    chk("refill_request_raised", {63'd0, saw}, 64'd1);
    gen_reset = 1'b1;
    @(negedge clk);
    gen_reset = 1'b0;
    chk("abort_mem_req", {63'd0, mem_req}, 64'd0);
    chk("abort_busy", {63'd0, cpu_busy}, 64'd0);
    chk("abort_hits", 64'(hit_count), 64'd0);
    chk("abort_misses", 64'(miss_count), 64'd0);
    ref_clear_lines();
    ref_hits   = 0;
    ref_misses = 0;
    stale_req  = stale_req + 1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_done || cpu_busy || mem_req) saw = 1'b1;
    end
    chk("stale_ack_ignored", {63'd0, saw}, 64'd0);
    $display("txn reset during refill, stale ack issued");
    mem_auto = 1'b1;

    // Random traffic over a few aliasing lines
    for (int n = 0; n < 150; n++) begin
      logic [ADDR_W-1:0] a;
      logic [LINE_W-1:0] d;
      bit                w;
      bit                f;
      a = ADDR_W'(($urandom_range(0, 3) << INDEX_W) | $urandom_range(0, 3));
      d = {$urandom, $urandom};
      w = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 15) == 0);
      do_txn(w, a, d, f, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
